gba_dma_trigger_arb: RTL and testbench
======================================

// Module: gba_dma_trigger_arb
// PURPOSE
//  Turns display-timing and sound-FIFO events into DMA start requests for the four DMA channels.
//  Inputs: hblank_trigger, vblank_trigger, videodma_start and videodma_stop from the GPU timing generator; FIFO requests from sound.
//  Holds one pending flag per channel and arbitrates by fixed priority (ch0 highest).
//  Issues one request at a time to the DMA transfer engine over a valid/ready handshake.
// PARAMETERS
//  VIDEO_CH       3        channel whose special timing (mode 3) is video capture
//  SOUND_CH_MASK  4'b0110  channels whose special timing (mode 3) is sound FIFO request
//  DROP_CNT_W     8        width of each drop counter (only with DMA_TRIGGER_STATS_EN)
// PORTS
//  mclk            in   1   clock
//  reset           in   1   synchronous, active-high reset
//  ch_enable       in   4   per-channel DMA enable (DMAxCNT_H bit15)
//  ch_timing       in   8   2 bits per channel: 0 immediate, 1 vblank, 2 hblank, 3 special
//  ch_start_imm    in   4   one-cycle pulse when enable is written 0->1
//  hblank_trigger  in   1   one-cycle pulse at hblank entry
//  vblank_trigger  in   1   one-cycle pulse at vblank entry
//  videodma_start  in   1   one-cycle pulse, per-line video capture start
//  videodma_stop   in   1   one-cycle pulse, end of video capture frame
//  sound_fifo_req  in   2   pulses from FIFO A/B; [0] maps to ch1, [1] maps to ch2
//  req_ready       in   1   engine accepts the current request
//  ch_done         in   4   one-cycle pulse when the engine finishes a channel's block
//  req_valid       out  1   request present
//  req_channel     out  2   channel being requested or active
//  ch_active       out  4   one-hot channel currently owned by the engine
//  pending         out  4   pending flags
//  video_stop      out  1   one-cycle pulse: engine must clear VIDEO_CH enable
//  drop_count      out  4*DROP_CNT_W  per-channel dropped-trigger counts (stats build only)
// BEHAVIOUR
//  All inputs are synchronous to mclk. Outputs are registered.
//  Reset values:
//   - all outputs 0; state IDLE; pending 0.
//  Trigger match for channel c: ch_enable[c] and one of:
//   - mode 0 with ch_start_imm[c];
//   - mode 1 with vblank_trigger;
//   - mode 2 with hblank_trigger;
//   - mode 3 with videodma_start (c == VIDEO_CH);
//   - mode 3 with the mapped sound_fifo_req bit (SOUND_CH_MASK[c]).
//  Mode 3 on ch0 is prohibited and never matches.
//  A match sets pending[c] on the next edge.
//  Set wins over the grant-clear in the same cycle: the flag stays 1.
//  A match while pending[c] is already 1 is a drop; the flag stays 1.
//  ch_enable[c] == 0 clears pending[c] in the same cycle.
//  State machine:
//   - IDLE: if pending != 0, select the lowest-index pending channel; next edge go to REQ with req_valid=1 and req_channel=sel.
//   - REQ: req_channel held stable while req_valid=1.
//     On req_ready: clear pending[sel], set ch_active one-hot, req_valid=0, go ACTIVE.
//     If ch_enable[sel] drops before req_ready: req_valid=0, go IDLE (abort, no grant).
//     A higher-priority pending channel does not replace the request while in REQ.
//   - ACTIVE: on ch_done[req_channel], ch_active=0, go IDLE.
//     ch_done for other channels is ignored.
//     No preemption: the active channel runs to ch_done.
//  Latency:
//   - trigger at edge T gives pending at T+1 and req_valid at T+2.
//   - after ch_done at T, the next req_valid appears at T+2 at the earliest.
//  videodma_stop:
//   - clears pending[VIDEO_CH] in that cycle; a same-cycle videodma_start is ignored.
//   - pulses video_stop on the next edge.
//   - if VIDEO_CH is active, it stays active until ch_done.
//  Reset mid-operation:
//   - returns to IDLE immediately and drops req_valid.
//   - the engine must treat reset as an abort.
// CONFIGURATION
//  DMA_TRIGGER_STATS_EN defined:
//   - per-channel saturating drop counters (DROP_CNT_W bits), +1 per dropped trigger; cleared by reset.
//  Not defined:
//   - no counter logic is built; drop_count is tied to 0.
// TESTING
//  1. ch0 en, mode 2; one hblank_trigger at T -> pending[0]=1 at T+1; req_valid=1 with req_channel=0 at T+2; req_ready -> ch_active=4'b0001; ch_done[0] -> IDLE.
//  2. ch1 mode 1 and ch2 mode 1, single vblank_trigger -> ch1 granted first; ch2 requested 2 cycles after ch_done[1].
//  3. ch3 mode 3; 3x videodma_start then videodma_stop -> three grants, video_stop pulse 1 cycle, pending[3]=0.
//  4. Hold req_ready=0 and drop ch_enable[2] while REQ on ch2 -> req_valid=0 next edge, pending[2]=0, IDLE.
//  5. Two hblank_triggers while ch0 ACTIVE -> pending[0] stays 1; with STATS_EN drop_count[0] increments by 1; without it drop_count=0.
//  6. Assert reset while ACTIVE -> next edge: all outputs 0, pending 0.

Source files
------------

// File: rtl/gba_dma_trigger_arb.sv
// Converts display-timing and sound-FIFO events into prioritised DMA start requests.
// Optional drop statistics are enabled with `define DMA_TRIGGER_STATS_EN.
module gba_dma_trigger_arb #(
    parameter int         VIDEO_CH      = 3,
    parameter logic [3:0] SOUND_CH_MASK = 4'b0110,
    parameter int         DROP_CNT_W    = 8
) (
    input  logic                    mclk,
    input  logic                    reset,
    input  logic [3:0]              ch_enable,
    input  logic [7:0]              ch_timing,
    input  logic [3:0]              ch_start_imm,
    input  logic                    hblank_trigger,
    input  logic                    vblank_trigger,
    input  logic                    videodma_start,
    input  logic                    videodma_stop,
    input  logic [1:0]              sound_fifo_req,
    input  logic                    req_ready,
    input  logic [3:0]              ch_done,
    output logic                    req_valid,
    output logic [1:0]              req_channel,
    output logic [3:0]              ch_active,
    output logic [3:0]              pending,
    output logic                    video_stop,
    output logic [4*DROP_CNT_W-1:0] drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t     state_r, state_n;
    logic       req_valid_r, req_valid_n;
    logic [1:0] req_channel_r, req_channel_n;
    logic [3:0] ch_active_r, ch_active_n;
    logic [3:0] pending_r, pending_n;
    logic       video_stop_r;
    logic [3:0] match_s;
    logic [3:0] drop_s;
    logic [1:0] sel_s;
    logic       grant_s;

    for (genvar c = 0; c < 4; c++) begin : g_match
        logic [1:0] mode_s;
        logic       sound_bit_s;
        logic       special_s;
        logic       hit_s;

        assign mode_s      = ch_timing[2*c +: 2];
        assign sound_bit_s = (c == 1) ? sound_fifo_req[0] :
                             (c == 2) ? sound_fifo_req[1] : 1'b0;
        // Mode 3 on ch0 is prohibited; a start coinciding with stop is discarded.
        assign special_s   = (c != 0) &&
                             (((c == VIDEO_CH) && videodma_start && !videodma_stop) ||
                              (SOUND_CH_MASK[c] && sound_bit_s));

        // Per-channel trigger decode by timing mode
        always_comb begin
            case (mode_s)
                2'd0:    hit_s = ch_start_imm[c];
                2'd1:    hit_s = vblank_trigger;
                2'd2:    hit_s = hblank_trigger;
                2'd3:    hit_s = special_s;
                default: hit_s = 1'b0;
            endcase
        end

        assign match_s[c] = ch_enable[c] && hit_s;
    end

    // Pending flag update: disable and video stop clear, set beats grant-clear
    always_comb begin
        pending_n = pending_r;
        drop_s    = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            if (!ch_enable[c]) begin
                pending_n[c] = 1'b0;
            end else if (videodma_stop && (c == VIDEO_CH)) begin
                pending_n[c] = 1'b0;
            end else if (match_s[c]) begin
                pending_n[c] = 1'b1;
                drop_s[c]    = pending_r[c];
            end else if (grant_s && (req_channel_r == 2'(c))) begin
                pending_n[c] = 1'b0;
            end else begin
                pending_n[c] = pending_r[c];
            end
        end
    end

    // Fixed-priority select, ch0 highest
    always_comb begin
        casez (pending_r)
            4'b???1: sel_s = 2'd0;
            4'b??10: sel_s = 2'd1;
            4'b?100: sel_s = 2'd2;
            4'b1000: sel_s = 2'd3;
            default: sel_s = 2'd0;
        endcase
    end

    // Request/grant state machine next-state and output values
    always_comb begin
        state_n       = state_r;
        req_valid_n   = req_valid_r;
        req_channel_n = req_channel_r;
        ch_active_n   = ch_active_r;
        grant_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != 4'b0000) begin
                    state_n       = ST_REQ;
                    req_valid_n   = 1'b1;
                    req_channel_n = sel_s;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!ch_enable[req_channel_r]) begin
                    state_n     = ST_IDLE;
                    req_valid_n = 1'b0;
                end else if (req_ready) begin
                    grant_s     = 1'b1;
                    state_n     = ST_ACTIVE;
                    req_valid_n = 1'b0;
                    ch_active_n = 4'b0001 << req_channel_r;
                end else begin
                    state_n = ST_REQ;
                end
            end
            ST_ACTIVE: begin
                if (ch_done[req_channel_r]) begin
                    state_n     = ST_IDLE;
                    ch_active_n = 4'b0000;
                end else begin
                    state_n = ST_ACTIVE;
                end
            end
            default: begin
                state_n       = ST_IDLE;
                req_valid_n   = 1'b0;
                req_channel_n = 2'd0;
                ch_active_n   = 4'b0000;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            req_valid_r   <= 1'b0;
            req_channel_r <= 2'd0;
            ch_active_r   <= 4'b0000;
            pending_r     <= 4'b0000;
            video_stop_r  <= 1'b0;
        end else begin
            state_r       <= state_n;
            req_valid_r   <= req_valid_n;
            req_channel_r <= req_channel_n;
            ch_active_r   <= ch_active_n;
            pending_r     <= pending_n;
            video_stop_r  <= videodma_stop;
        end
    end

    assign req_valid   = req_valid_r;
    assign req_channel = req_channel_r;
    assign ch_active   = ch_active_r;
    assign pending     = pending_r;
    assign video_stop  = video_stop_r;

`ifdef DMA_TRIGGER_STATS_EN
    localparam logic [DROP_CNT_W-1:0] CNT_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_CNT_W-1:0] CNT_MAX = {DROP_CNT_W{1'b1}};

    logic [DROP_CNT_W-1:0] drop_cnt_r [4];

    // Saturating per-channel dropped-trigger counters
    always_ff @(posedge mclk) begin
        if (reset) begin
            for (int c = 0; c < 4; c++) drop_cnt_r[c] <= '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (drop_s[c] && (drop_cnt_r[c] != CNT_MAX)) begin
                    drop_cnt_r[c] <= drop_cnt_r[c] + CNT_ONE;
                end else begin
                    drop_cnt_r[c] <= drop_cnt_r[c];
                end
            end
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_cnt_out
        assign drop_count[c*DROP_CNT_W +: DROP_CNT_W] = drop_cnt_r[c];
    end
`else
    logic drop_unused_s;
    assign drop_unused_s = ^drop_s;
    assign drop_count    = '0;
`endif

endmodule

// File: tb/tb_gba_dma_trigger_arb.sv
// Directed bench: grants are checked by a scoreboard monitor, state by direct comparisons.
module tb_gba_dma_trigger_arb;

    logic        mclk;
    logic        reset;
    logic [3:0]  ch_enable;
    logic [7:0]  ch_timing;
    logic [3:0]  ch_start_imm;
    logic        hblank_trigger;
    logic        vblank_trigger;
    logic        videodma_start;
    logic        videodma_stop;
    logic [1:0]  sound_fifo_req;
    logic        req_ready;
    logic [3:0]  ch_done;
    logic        req_valid;
    logic [1:0]  req_channel;
    logic [3:0]  ch_active;
    logic [3:0]  pending;
    logic        video_stop;
    logic [31:0] drop_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int vstop_exp = 0;

    gba_dma_trigger_arb dut (
        .mclk(mclk), .reset(reset), .ch_enable(ch_enable), .ch_timing(ch_timing),
        .ch_start_imm(ch_start_imm), .hblank_trigger(hblank_trigger),
        .vblank_trigger(vblank_trigger), .videodma_start(videodma_start),
        .videodma_stop(videodma_stop), .sound_fifo_req(sound_fifo_req),
        .req_ready(req_ready), .ch_done(ch_done), .req_valid(req_valid),
        .req_channel(req_channel), .ch_active(ch_active), .pending(pending),
        .video_stop(video_stop), .drop_count(drop_count)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic grant(input int ch);
        exp_q.push_back(ch);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
    endtask

    // Scoreboard monitor: compares each accepted request and each video_stop pulse
    always @(negedge mclk) begin
        if (reset === 1'b0 && req_valid === 1'b1 && req_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL grant_unexpected: got channel %0d expected none", req_channel);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (req_channel !== 2'(e)) begin
                    n_err++;
                    $display("FAIL grant_channel: got %0d expected %0d", req_channel, e);
                end
            end
        end
        if (video_stop === 1'b1) begin
            n_cmp++;
            if (vstop_exp == 0) begin
                n_err++;
                $display("FAIL video_stop_unexpected: got 1 expected 0");
            end else begin
                vstop_exp--;
            end
        end
    end

    initial begin
        logic [31:0] exp_drop;
        reset = 1'b1; ch_enable = 4'b0000; ch_timing = 8'h00; ch_start_imm = 4'b0000;
        hblank_trigger = 1'b0; vblank_trigger = 1'b0; videodma_start = 1'b0;
        videodma_stop = 1'b0; sound_fifo_req = 2'b00; req_ready = 1'b0; ch_done = 4'b0000;
        tick(); tick();
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_ch_active", 32'(ch_active), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_drop_count", drop_count, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_req_valid", 32'(req_valid), 32'd0);

        // 1: ch0 hblank, latency T+1 / T+2
        ch_enable = 4'b0001; ch_timing = 8'h02;
        tick();
        hblank_trigger = 1'b1; tick(); hblank_trigger = 1'b0;
        check("t1_pending", 32'(pending), 32'h1);
        check("t1_valid_early", 32'(req_valid), 32'd0);
        tick();
        check("t1_valid", 32'(req_valid), 32'd1);
        check("t1_channel", 32'(req_channel), 32'd0);
        grant(0);
        check("t1_active", 32'(ch_active), 32'h1);
        check("t1_valid_off", 32'(req_valid), 32'd0);
        check("t1_pending_clr", 32'(pending), 32'd0);
        ch_done = 4'b0001; tick(); ch_done = 4'b0000;
        check("t1_done", 32'(ch_active), 32'd0);
        tick();
        check("t1_idle", 32'(req_valid), 32'd0);

        // 2: ch1 and ch2 on one vblank; ch1 first, ch2 two cycles after done
        ch_enable = 4'b0110; ch_timing = 8'h14;
        vblank_trigger = 1'b1; tick(); vblank_trigger = 1'b0;
        check("t2_pending", 32'(pending), 32'h6);
        tick();
        check("t2_channel1", 32'(req_channel), 32'd1);
        check("t2_valid1", 32'(req_valid), 32'd1);
        grant(1);
        check("t2_active1", 32'(ch_active), 32'h2);
        check("t2_pending2", 32'(pending), 32'h4);
        ch_done = 4'b0100; tick(); ch_done = 4'b0000;
        check("t2_other_done", 32'(ch_active), 32'h2);
        ch_done = 4'b0010; tick(); ch_done = 4'b0000;
        check("t2_gap", 32'(req_valid), 32'd0);
        check("t2_active_clr", 32'(ch_active), 32'd0);
        tick();
        check("t2_valid2", 32'(req_valid), 32'd1);
        check("t2_channel2", 32'(req_channel), 32'd2);
        grant(2);
        check("t2_active2", 32'(ch_active), 32'h4);
        ch_done = 4'b0100; tick(); ch_done = 4'b0000;
        tick();

        // 3: video capture on ch3, then stop with a same-cycle start
        ch_enable = 4'b1000; ch_timing = 8'hC0;
        for (int i = 0; i < 3; i++) begin
            videodma_start = 1'b1; tick(); videodma_start = 1'b0;
            tick();
            check("t3_channel", 32'(req_channel), 32'd3);
            grant(3);
            check("t3_active", 32'(ch_active), 32'h8);
            ch_done = 4'b1000; tick(); ch_done = 4'b0000;
            tick();
        end
        videodma_stop = 1'b1; videodma_start = 1'b1; vstop_exp++;
        tick();
        videodma_stop = 1'b0; videodma_start = 1'b0;
        check("t3_video_stop", 32'(video_stop), 32'd1);
        check("t3_pending", 32'(pending), 32'd0);
        tick();
        check("t3_video_stop_off", 32'(video_stop), 32'd0);
        check("t3_no_req", 32'(req_valid), 32'd0);
        // sound FIFO on ch1; ch0 in mode 3 must not react
        ch_enable = 4'b1011; ch_timing = 8'hCF;
        sound_fifo_req = 2'b11; tick(); sound_fifo_req = 2'b00;
        check("t3_sound_pending", 32'(pending), 32'h2);
        tick();
        check("t3_sound_channel", 32'(req_channel), 32'd1);
        grant(1);
        ch_done = 4'b0010; tick(); ch_done = 4'b0000;
        tick();
        check("t3_sound_idle", 32'(req_valid), 32'd0);

        // 4: abort on enable drop; higher priority does not replace the request
        ch_enable = 4'b0100; ch_timing = 8'h00;
        ch_start_imm = 4'b0100; tick(); ch_start_imm = 4'b0000;
        tick();
        check("t4_channel", 32'(req_channel), 32'd2);
        ch_enable = 4'b0101; ch_start_imm = 4'b0001; tick(); ch_start_imm = 4'b0000;
        check("t4_pending_both", 32'(pending), 32'h5);
        check("t4_no_replace", 32'(req_channel), 32'd2);
        tick();
        check("t4_hold_valid", 32'(req_valid), 32'd1);
        ch_enable = 4'b0001;
        tick();
        check("t4_abort_valid", 32'(req_valid), 32'd0);
        check("t4_abort_pending", 32'(pending), 32'h1);
        tick();
        check("t4_next_valid", 32'(req_valid), 32'd1);
        check("t4_next_channel", 32'(req_channel), 32'd0);
        grant(0);
        check("t4_active0", 32'(ch_active), 32'h1);

        // 5: two hblanks while ch0 active -> one set plus one drop
        ch_timing = 8'h02;
        check("t5_drop_before", drop_count, 32'd0);
        hblank_trigger = 1'b1; tick();
        check("t5_pending_set", 32'(pending), 32'h1);
        tick(); hblank_trigger = 1'b0;
        check("t5_pending_hold", 32'(pending), 32'h1);
        check("t5_still_active", 32'(ch_active), 32'h1);
`ifdef DMA_TRIGGER_STATS_EN
        exp_drop = 32'h0000_0001;
`else
        exp_drop = 32'h0000_0000;
`endif
        check("t5_drop_count", drop_count, exp_drop);

        // 6: reset while active
        reset = 1'b1; tick();
        check("t6_req_valid", 32'(req_valid), 32'd0);
        check("t6_channel", 32'(req_channel), 32'd0);
        check("t6_active", 32'(ch_active), 32'd0);
        check("t6_pending", 32'(pending), 32'd0);
        check("t6_video_stop", 32'(video_stop), 32'd0);
        check("t6_drop_count", drop_count, 32'd0);
        reset = 1'b0; ch_enable = 4'b0000;
        tick();
        check("t6_after_valid", 32'(req_valid), 32'd0);

        check("sb_grants_left", 32'(exp_q.size()), 32'd0);
        check("sb_vstop_left", 32'(vstop_exp), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
